// File: rtl/uart_rx_buf_pkg.sv
// Shared UART definitions: baud divisor table and receiver FSM state encodings.
// The transmit stage uses the same divisor table, so both ends agree on bit timing.
package uart_rx_buf_pkg;

  // Wide enough for a 9600 baud divisor at clock rates of up to about 600 MHz.
  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_e;

  // Clocks per bit for a given choose code, integer-truncated.
  function automatic logic [CNT_W-1:0] baud_div(input int clk_freq, input logic [1:0] sel);
    int baud;
    case (sel)
      2'b00:   baud = 9600;
      2'b01:   baud = 19200;
      2'b10:   baud = 38400;
      default: baud = 115200;
    endcase
    return CNT_W'(clk_freq / baud);
  endfunction

endpackage

// File: rtl/uart_rx_buf_rx_fifo.sv
// Receive byte FIFO, first-word-fall-through, register-array storage.
// A push into a full FIFO is dropped and reported, unless a pop in the same cycle frees a slot.
module uart_rx_buf_rx_fifo #(
  parameter int FIFO_AW = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic       empty,
  output logic       full,
  output logic       overrun
);

  localparam int DEPTH = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0] DEPTH_C = (FIFO_AW + 1)'(DEPTH);

  logic [7:0]         mem_q [DEPTH];
  logic [7:0]         mem_d [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   count_q, count_d;
  logic               overrun_q, overrun_d;
  logic               pop;
  logic               full_w;
  logic               do_write;

  assign full_w   = (count_q == DEPTH_C);
  assign pop      = rd_en && (count_q != '0);
  assign do_write = wr_en && (!full_w || pop);

  // Next-state for storage, pointers, occupancy and the drop pulse.
  always_comb begin
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    overrun_d = wr_en && full_w && !pop;
    if (do_write) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_write, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // FIFO state registers; storage is cleared so the head reads 8'h00 out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign empty   = (count_q == '0);
  assign full    = full_w;
  assign overrun = overrun_q;

endmodule

// File: rtl/uart_rx_buf.sv
// 8N1 UART receiver feeding a small FWFT byte FIFO.
//
//   state | meaning
//   IDLE  | line idle, waiting for a low level on the synchronised input
//   START | timing to the middle of the start bit to reject glitches
//   DATA  | sampling 8 data bits mid-bit, LSB first
//   STOP  | sampling the stop bit; high pushes the byte, low flags a framing error
//
// The FSM leaves STOP at mid stop bit so back-to-back frames need no extra idle time.
module uart_rx_buf
  import uart_rx_buf_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int FIFO_AW  = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  input  logic [1:0] choose,
  input  logic       rd_en,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       fifo_full,
  output logic       frame_err,
  output logic       overrun
);

  localparam logic [CNT_W-1:0] DIV_0 = baud_div(CLK_FREQ, 2'b00);
  localparam logic [CNT_W-1:0] DIV_1 = baud_div(CLK_FREQ, 2'b01);
  localparam logic [CNT_W-1:0] DIV_2 = baud_div(CLK_FREQ, 2'b10);
  localparam logic [CNT_W-1:0] DIV_3 = baud_div(CLK_FREQ, 2'b11);

  logic             rx_meta_q, rx_sync_q;
  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             frame_err_q, frame_err_d;
  logic [CNT_W-1:0] div_sel;
  logic             expired;
  logic             push;
  logic             fifo_empty;

  assign expired = (cnt_q == '0);

  // Divisor for the current choose code; only captured when a frame starts.
  always_comb begin
    case (choose)
      2'b00:   div_sel = DIV_0;
      2'b01:   div_sel = DIV_1;
      2'b10:   div_sel = DIV_2;
      default: div_sel = DIV_3;
    endcase
  end

  // Two-flop synchroniser; resets to the idle-high line level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx_in;
      rx_sync_q <= rx_meta_q;
    end
  end

  // Receiver next-state: down-counter expiry marks each mid-bit sample point.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    div_d       = div_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    frame_err_d = 1'b0;
    push        = 1'b0;
    if (state_q != ST_IDLE && !expired) begin
      cnt_d = cnt_q - 1'b1;
    end
    case (state_q)
      ST_IDLE: begin
        if (!rx_sync_q) begin
          state_d = ST_START;
          div_d   = div_sel;
          cnt_d   = (div_sel >> 1) - 1'b1;
        end
      end
      ST_START: begin
        if (expired) begin
          if (!rx_sync_q) begin
            state_d   = ST_DATA;
            cnt_d     = div_q - 1'b1;
            bit_idx_d = 3'd0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_DATA: begin
        if (expired) begin
          shift_d   = {rx_sync_q, shift_q[7:1]};
          cnt_d     = div_q - 1'b1;
          bit_idx_d = bit_idx_q + 1'b1;
          if (bit_idx_q == 3'd7) begin
            state_d = ST_STOP;
          end
        end
      end
      ST_STOP: begin
        if (expired) begin
          state_d = ST_IDLE;
          if (rx_sync_q) begin
            push = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Receiver FSM, timing and shift registers; reset aborts any frame in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      div_q       <= DIV_3;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      div_q       <= div_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
    end
  end

  uart_rx_buf_rx_fifo #(
    .FIFO_AW(FIFO_AW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push),
    .wr_data (shift_q),
    .rd_en   (rd_en),
    .rd_data (rx_data),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .overrun (overrun)
  );

  assign rx_valid  = ~fifo_empty;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx_buf.sv
// Self-checking bench for uart_rx_buf, run at a 5 MHz clock so slow baud rates stay short.
// A queue model predicts FIFO contents and pulse outputs every cycle from the driven frames.
module tb_uart_rx_buf;
  import uart_rx_buf_pkg::*;

  localparam int CLK_HZ = 5_000_000;
  localparam int DEPTH  = 8;
  localparam int D00    = CLK_HZ / 9600;    // 520
  localparam int D01    = CLK_HZ / 19200;   // 260
  localparam int D11    = CLK_HZ / 115200;  // 43
  // start edge to visible push: 2 synchroniser flops + idle detect, half a bit, then 9 full bits
  localparam int FRONT_LAT = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_in;
  logic [1:0] choose;
  logic       rd_en;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       fifo_full;
  logic       frame_err;
  logic       overrun;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [7:0] mq[$];
  int         ev_cyc  [64];
  logic [7:0] ev_byte [64];
  logic       ev_ok   [64];
  int         ev_wr = 0;
  int         ev_rd = 0;
  logic       pop_pend   = 1'b0;
  logic       prev_valid = 1'b0;
  int         last_rise  = 0;
  int         fe_cnt     = 0;
  int         ov_cnt     = 0;

  uart_rx_buf #(
    .CLK_FREQ(CLK_HZ),
    .FIFO_AW (3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_in    (rx_in),
    .choose   (choose),
    .rd_en    (rd_en),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .fifo_full(fifo_full),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // One clock: update the model for the edge just taken, compare at negedge, return after next edge.
  task automatic tick();
    logic fe_x, ov_x, pop_eff;
    @(negedge clk);
    fe_x = 1'b0;
    ov_x = 1'b0;
    if (frame_err) fe_cnt++;
    if (overrun) ov_cnt++;
    if (rx_valid && !prev_valid) last_rise = cyc;
    prev_valid = rx_valid;
    if (!rst) begin
      mq.delete();
      ev_rd    = ev_wr;
      pop_pend = 1'b0;
      chk("rst_rx_valid", 32'(rx_valid), 0);
      chk("rst_fifo_full", 32'(fifo_full), 0);
      chk("rst_rx_data", 32'(rx_data), 0);
      chk("rst_frame_err", 32'(frame_err), 0);
      chk("rst_overrun", 32'(overrun), 0);
    end else begin
      pop_eff = pop_pend && (mq.size() != 0);
      if (pop_eff) void'(mq.pop_front());
      while (ev_rd < ev_wr && ev_cyc[ev_rd] < cyc) ev_rd++;
      if (ev_rd < ev_wr && ev_cyc[ev_rd] == cyc) begin
        if (!ev_ok[ev_rd]) fe_x = 1'b1;
        else if (mq.size() == DEPTH) ov_x = 1'b1;
        else mq.push_back(ev_byte[ev_rd]);
        ev_rd++;
      end
      chk("m_rx_valid", 32'(rx_valid), 32'(mq.size() != 0));
      chk("m_fifo_full", 32'(fifo_full), 32'(mq.size() == DEPTH));
      chk("m_frame_err", 32'(frame_err), 32'(fe_x));
      chk("m_overrun", 32'(overrun), 32'(ov_x));
      if (mq.size() != 0) chk("m_rx_data", 32'(rx_data), 32'(mq[0]));
      pop_pend = rd_en;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Drive one 8N1 frame at div clocks per bit; stops early (line high) after max_cyc clocks.
  task automatic drive_frame(input logic [7:0] b, input logic stop_hi, input int div,
                             input int max_cyc);
    logic [9:0] bits;
    int n;
    bits = {stop_hi, b, 1'b0};
    if (ev_wr < 64) begin
      ev_cyc[ev_wr]  = cyc + FRONT_LAT + div / 2 + 9 * div;
      ev_byte[ev_wr] = b;
      ev_ok[ev_wr]   = stop_hi;
      ev_wr++;
    end
    n = 0;
    for (int i = 0; i < 10; i++) begin
      rx_in = bits[i];
      for (int k = 0; k < div; k++) begin
        if (n == max_cyc) begin
          rx_in = 1'b1;
          return;
        end
        tick();
        n++;
      end
    end
    rx_in = 1'b1;
  endtask

  task automatic read_byte(input logic [7:0] exp, input string nm);
    chk({nm, "_valid"}, 32'(rx_valid), 1);
    chk(nm, 32'(rx_data), 32'(exp));
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  initial begin
    int c0;
    int fe0;
    int ov0;
    rst    = 1'b1;
    rx_in  = 1'b1;
    rd_en  = 1'b0;
    choose = 2'b11;
    #2 rst = 1'b0;
    idle(3);
    chk("init_rx_data", 32'(rx_data), 0);
    chk("init_rx_valid", 32'(rx_valid), 0);
    rst = 1'b1;
    idle(5);

    // divisor table at the nominal 50 MHz clock
    chk("div_9600", 32'(baud_div(50_000_000, 2'b00)), 5208);
    chk("div_19200", 32'(baud_div(50_000_000, 2'b01)), 2604);
    chk("div_38400", 32'(baud_div(50_000_000, 2'b10)), 1302);
    chk("div_115200", 32'(baud_div(50_000_000, 2'b11)), 434);

    // single byte at the fastest rate; choose changes mid-frame without disturbing it
    c0 = cyc;
    fork
      drive_frame(8'h35, 1'b1, D11, 10 * D11);
      begin
        repeat (100) @(posedge clk);
        #1 choose = 2'b00;
      end
    join
    chk("latency_35", 32'(last_rise - c0), 411);
    read_byte(8'h35, "rd_35");
    chk("empty_after_35", 32'(rx_valid), 0);

    // pop on an empty FIFO must not move the pointers
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    idle(3);

    // three back-to-back frames at 9600 baud
    fe0 = fe_cnt;
    drive_frame(8'h01, 1'b1, D00, 10 * D00);
    drive_frame(8'h7F, 1'b1, D00, 10 * D00);
    drive_frame(8'hA5, 1'b1, D00, 10 * D00);
    idle(10);
    chk("b2b_no_ferr", 32'(fe_cnt - fe0), 0);
    read_byte(8'h01, "b2b_0");
    read_byte(8'h7F, "b2b_1");
    read_byte(8'hA5, "b2b_2");
    chk("b2b_empty", 32'(rx_valid), 0);

    // short low glitch shorter than half a bit
    choose = 2'b01;
    idle(5);
    rx_in = 1'b0;
    idle(100);
    rx_in = 1'b1;
    idle(400);
    chk("glitch_no_push", 32'(rx_valid), 0);
    chk("glitch_no_ferr", 32'(fe_cnt - fe0), 0);

    // good byte, then a frame with a low stop bit
    drive_frame(8'h44, 1'b1, D01, 10 * D01);
    drive_frame(8'hC3, 1'b0, D01, 10 * D01);
    idle(300);
    chk("ferr_one_cycle", 32'(fe_cnt - fe0), 1);
    read_byte(8'h44, "ferr_keep_44");
    chk("ferr_no_push", 32'(rx_valid), 0);

    // fill to full, then overflow by one
    choose = 2'b11;
    idle(5);
    ov0 = ov_cnt;
    for (int i = 1; i <= 8; i++) drive_frame(8'(8'h10 + i), 1'b1, D11, 10 * D11);
    chk("full_after_8", 32'(fifo_full), 1);
    drive_frame(8'h19, 1'b1, D11, 10 * D11);
    idle(5);
    chk("overrun_pulse", 32'(ov_cnt - ov0), 1);
    chk("full_after_9", 32'(fifo_full), 1);
    for (int i = 1; i <= 8; i++) read_byte(8'(8'h10 + i), "ovf_rd");
    chk("ovf_drained", 32'(rx_valid), 0);

    // refill, then push and pop in the same cycle while full
    for (int i = 1; i <= 8; i++) drive_frame(8'(8'h20 + i), 1'b1, D11, 10 * D11);
    ov0 = ov_cnt;
    fork
      drive_frame(8'hEE, 1'b1, D11, 10 * D11);
      begin
        repeat (410) @(posedge clk);
        #1 rd_en = 1'b1;
        @(posedge clk);
        #1 rd_en = 1'b0;
      end
    join
    idle(3);
    chk("pushpop_no_ovr", 32'(ov_cnt - ov0), 0);
    chk("pushpop_full", 32'(fifo_full), 1);
    for (int i = 2; i <= 8; i++) read_byte(8'(8'h20 + i), "pushpop_rd");
    read_byte(8'hEE, "pushpop_last");
    chk("pushpop_empty", 32'(rx_valid), 0);

    // reset mid-DATA with a byte already queued, then a clean frame
    drive_frame(8'h77, 1'b1, D11, 10 * D11);
    drive_frame(8'h00, 1'b1, D11, 150);
    rst = 1'b0;
    tick();
    chk("midrst_valid", 32'(rx_valid), 0);
    chk("midrst_data", 32'(rx_data), 0);
    chk("midrst_full", 32'(fifo_full), 0);
    rst = 1'b1;
    idle(50);
    drive_frame(8'h5A, 1'b1, D11, 10 * D11);
    idle(5);
    read_byte(8'h5A, "after_rst_5a");
    chk("after_rst_empty", 32'(rx_valid), 0);
    idle(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
